fsm_bit_serializer: RTL and testbench
=====================================

Name: fsm_bit_serializer

Overview:
Upstream feeder for the 010 sequence-detector FSM. Accepts parallel words over a valid/ready handshake and buffers them in a small FIFO. Shifts each word out one bit per clock on `x`, which drives the detector's serial input directly. Between words the line holds an idle level so the detector cannot see false 010 patterns.

Parameters:
DATA_W, 8, width of each parallel input word (2..16)
FIFO_DEPTH, 4, number of buffered words; power of two, >= 2
IDLE_BIT, 1'b1, level driven on `x` when no word is shifting; 1 keeps the detector in IDLE
MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
in_data  input  DATA_W  parallel word to serialize
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  block can accept a word; transfer occurs when in_valid && in_ready at a rising edge
x  output  1  serial bit to the detector, registered
x_valid  output  1  high while x carries a data bit, low on idle fill
busy  output  1  high when a word is shifting or the FIFO is non-empty
words_sent  output  10  count of fully shifted words; wraps 1023 -> 0

Behaviour:
- Reset is the only reset source.
  - While rst = 0: x = IDLE_BIT, x_valid = 0, busy = 0, words_sent = 0, FIFO empty, bit counter = 0, state = SER_IDLE.
  - in_ready is forced to 0 while rst is low.
  - Reset asserted mid-word aborts the word immediately. The partial word is not counted and FIFO contents are discarded.
- in_ready = !fifo_full (combinational from the FIFO count).
  - When the FIFO is full, a write is refused even if a read occurs on the same edge. No bypass path.
- FIFO read and write on the same edge are both performed when not full. Occupancy is unchanged.
- State machine, ser_state_e:
  - SER_IDLE:
    - x = IDLE_BIT, x_valid = 0.
    - If the FIFO is non-empty at a rising edge: pop the word into the shift register, drive the first bit on x, set x_valid = 1, go to SER_SHIFT with bit_cnt = 0.
  - SER_SHIFT:
    - Each edge advances bit_cnt and shifts the next bit onto x.
    - On the edge after the last bit (bit_cnt = FRAME_W-1), words_sent increments.
    - If the FIFO is non-empty on that edge, the next word loads on the same edge. This gives back-to-back frames with no idle gap.
    - Otherwise return to SER_IDLE, driving x = IDLE_BIT and x_valid = 0.
- FRAME_W = DATA_W, or DATA_W + 1 with PARITY_EN.
- Latency:
  - A word accepted at edge E0 into an empty FIFO with SER_IDLE pops at E1. Its first bit is visible on x after E1.
  - Its last bit is visible after E1 + FRAME_W - 1.
- Bit order follows MSB_FIRST. The shift register is DATA_W wide. bit_cnt is $clog2(FRAME_W+1) wide.
- words_sent is a 10-bit unsigned counter that wraps without saturation.
- busy = (state == SER_SHIFT) || !fifo_empty.

Optional Feature:
- Macro: FSM_SER_PARITY_EN
- Defined:
  - After the DATA_W data bits, one extra even-parity bit (XOR of the word) is shifted, with x_valid = 1.
  - FRAME_W = DATA_W + 1. words_sent increments only after the parity bit.
- Undefined: no parity bit, FRAME_W = DATA_W, and no parity logic is present.

Decomposition:
- Shared package Q3 gains:
  - typedef enum ser_state_e {SER_IDLE, SER_SHIFT}
  - localparam SER_CNT_W = 10
  - a transaction class fsm_ser_transaction with randomized data, valid, and rst. rst is constrained low with weight 1 vs 99.
- One sub-module, ser_fifo: a synchronous FIFO parameterized by DATA_W and FIFO_DEPTH, with the same clk/rst. It exposes wr_en, rd_en, full, empty and dout (first-word-fallthrough).
- The shift FSM lives in fsm_bit_serializer.

Test Plan:
- Reset check:
  - Hold rst = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, x = 1, x_valid = 0, busy = 0, words_sent = 0.
  - Release rst, stay idle -> x stays 1.
- Single word:
  - Write 8'h52, MSB_FIRST = 1 -> after the pop edge, x = 0,1,0,1,0,0,1,0 on 8 consecutive cycles with x_valid = 1.
  - Then x = 1, x_valid = 0, words_sent = 1.
  - The chained FSM_010 reports users_count = 2.
- Back-to-back:
  - Write 8'h00, 8'hFF, 8'hA5 on 3 consecutive cycles -> 24 contiguous x_valid cycles with no gap.
  - words_sent = 3 and busy falls on the edge after the 24th bit.
- Full FIFO:
  - With FIFO_DEPTH = 4, hold in_valid = 1 for 6 cycles -> in_ready drops once occupancy hits 4.
  - Exactly the accepted words appear on x, in order, with none lost or duplicated.
- Mid-word reset:
  - Pulse rst low during bit 3 of 8'hC3 -> x = 1 on the reset assertion, words_sent = 0, FIFO empty.
  - After release, the next written word serializes from bit 0.
- Parity (FSM_SER_PARITY_EN defined):
  - Send 8'h07 -> 9 valid bits 0,0,0,0,0,1,1,1,1 (parity 1).
  - words_sent increments only after the 9th bit.

Source files
------------

// File: rtl/fsm_bit_serializer_pkg.sv
// Shared types for the bit serializer feeding the 010 sequence detector.
package fsm_bit_serializer_pkg;

    typedef enum logic [0:0] {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;

    localparam int unsigned SER_CNT_W = 10;

endpackage

// File: rtl/ser_fifo.sv
// Synchronous first-word-fallthrough FIFO buffering serializer input words.
module ser_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_ok, rd_ok;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // A full FIFO refuses writes even when a read happens on the same edge.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (wr_ok && !rd_ok)      count_d = count_q + CNT_W'(1);
        else if (!wr_ok && rd_ok) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/fsm_bit_serializer.sv
// Buffers parallel words and shifts them out one bit per clock on x.
// Optional even-parity trailer bit enabled by defining FSM_SER_PARITY_EN.
module fsm_bit_serializer
    import fsm_bit_serializer_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic        IDLE_BIT   = 1'b1,
    parameter int unsigned MSB_FIRST  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 x,
    output logic                 x_valid,
    output logic                 busy,
    output logic [SER_CNT_W-1:0] words_sent
);

`ifdef FSM_SER_PARITY_EN
    localparam int unsigned FRAME_W = DATA_W + 1;
`else
    localparam int unsigned FRAME_W = DATA_W;
`endif
    localparam int unsigned          BIT_CNT_W = $clog2(FRAME_W + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(FRAME_W - 1);

    ser_state_e             state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      shreg_q, shreg_d;
    logic                   x_q, x_d;
    logic                   x_valid_q, x_valid_d;
    logic [SER_CNT_W-1:0]   words_sent_q, words_sent_d;
`ifdef FSM_SER_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    logic              fifo_full, fifo_empty, fifo_wr, fifo_rd;
    logic [DATA_W-1:0] fifo_dout;
    logic              load, last_bit;

    assign in_ready = rst && !fifo_full;
    assign fifo_wr  = in_valid && in_ready;

    ser_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (fifo_wr),
        .din   (in_data),
        .rd_en (fifo_rd),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    function automatic logic head_bit(input logic [DATA_W-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
        return (MSB_FIRST != 0) ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= SER_IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            x_q          <= IDLE_BIT;
            x_valid_q    <= 1'b0;
            words_sent_q <= '0;
`ifdef FSM_SER_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            x_q          <= x_d;
            x_valid_q    <= x_valid_d;
            words_sent_q <= words_sent_d;
`ifdef FSM_SER_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    // Next-state: a waiting word is loaded on the same edge the previous frame ends.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        last_bit = (state_q == SER_SHIFT) && (bit_cnt_q == LAST_BIT);
        case (state_q)
            SER_IDLE: begin
                if (!fifo_empty) begin
                    load    = 1'b1;
                    state_d = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (last_bit) begin
                    if (!fifo_empty) load = 1'b1;
                    else             state_d = SER_IDLE;
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        x_d          = x_q;
        x_valid_d    = x_valid_q;
        words_sent_d = last_bit ? words_sent_q + SER_CNT_W'(1) : words_sent_q;
        fifo_rd      = load;
`ifdef FSM_SER_PARITY_EN
        parity_d     = parity_q;
`endif
        if (load) begin
            bit_cnt_d = '0;
            x_d       = head_bit(fifo_dout);
            shreg_d   = shift_out(fifo_dout);
            x_valid_d = 1'b1;
`ifdef FSM_SER_PARITY_EN
            parity_d  = ^fifo_dout;
`endif
        end else if (last_bit) begin
            bit_cnt_d = '0;
            x_d       = IDLE_BIT;
            x_valid_d = 1'b0;
        end else if (state_q == SER_SHIFT) begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            shreg_d   = shift_out(shreg_q);
`ifdef FSM_SER_PARITY_EN
            x_d       = (bit_cnt_q == BIT_CNT_W'(DATA_W - 1)) ? parity_q : head_bit(shreg_q);
`else
            x_d       = head_bit(shreg_q);
`endif
        end
    end

    assign x          = x_q;
    assign x_valid    = x_valid_q;
    assign words_sent = words_sent_q;
    assign busy       = (state_q == SER_SHIFT) || !fifo_empty;

endmodule

// File: tb/tb_fsm_bit_serializer.sv
// Directed self-checking bench for fsm_bit_serializer (8-bit, depth 4, MSB first).
module tb_fsm_bit_serializer;

`ifdef FSM_SER_PARITY_EN
    localparam int unsigned FW = 9;
`else
    localparam int unsigned FW = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready, x, x_valid, busy;
    logic [9:0] words_sent;

    int         tests = 0;
    int         fails = 0;
    logic [9:0] ws_exp = '0;

    fsm_bit_serializer #(
        .DATA_W     (8),
        .FIFO_DEPTH (4),
        .IDLE_BIT   (1'b1),
        .MSB_FIRST  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .x_valid    (x_valid),
        .busy       (busy),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    // Expected frame bit: MSB first, then the even-parity trailer at index 8.
    function automatic logic exp_bit(input logic [7:0] w, input int unsigned idx);
        if (idx >= 8) return ^w;
        return w[7 - idx];
    endfunction

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_data = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready cyc%0d got %b exp 0", i, in_ready); end
            tests++; if (x !== 1'b1) begin fails++; $display("FAIL reset_x cyc%0d got %b exp 1", i, x); end
            tests++; if (x_valid !== 1'b0) begin fails++; $display("FAIL reset_x_valid cyc%0d got %b exp 0", i, x_valid); end
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy cyc%0d got %b exp 0", i, busy); end
            tests++; if (words_sent !== 10'd0) begin fails++; $display("FAIL reset_words cyc%0d got %0d exp 0", i, words_sent); end
        end
        in_valid = 1'b0; rst = 1'b1; ws_exp = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++; if (x !== 1'b1) begin fails++; $display("FAIL idle_x cyc%0d got %b exp 1", i, x); end
            tests++; if (x_valid !== 1'b0) begin fails++; $display("FAIL idle_x_valid cyc%0d got %b exp 0", i, x_valid); end
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready cyc%0d got %b exp 1", i, in_ready); end
        end
    endtask

    task automatic test_single_word();
        logic [8:0] hv;
        hv = 9'b0_1010_0101;  // 8'h52 MSB first, then parity 1
        in_data = 8'h52; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        tests++; if (x_valid !== 1'b0) begin fails++; $display("FAIL single_prepop_valid got %b exp 0", x_valid); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_prepop_busy got %b exp 1", busy); end
        for (int i = 0; i < FW; i++) begin
            @(negedge clk);
            tests++; if (x !== hv[8 - i]) begin fails++; $display("FAIL single_bit%0d got %b exp %b", i, x, hv[8 - i]); end
            tests++; if (x_valid !== 1'b1) begin fails++; $display("FAIL single_valid%0d got %b exp 1", i, x_valid); end
        end
        tests++; if (words_sent !== ws_exp) begin fails++; $display("FAIL single_words_early got %0d exp %0d", words_sent, ws_exp); end
        @(negedge clk);
        ws_exp = ws_exp + 10'd1;
        tests++; if (x !== 1'b1) begin fails++; $display("FAIL single_after_x got %b exp 1", x); end
        tests++; if (x_valid !== 1'b0) begin fails++; $display("FAIL single_after_valid got %b exp 0", x_valid); end
        tests++; if (words_sent !== ws_exp) begin fails++; $display("FAIL single_words got %0d exp %0d", words_sent, ws_exp); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy got %b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [3];
        w = '{8'h00, 8'hFF, 8'hA5};
        fork
            begin
                in_data = 8'h00; in_valid = 1'b1;
                @(negedge clk); in_data = 8'hFF;
                @(negedge clk); in_data = 8'hA5;
                @(negedge clk); in_valid = 1'b0;
            end
            begin
                @(negedge clk);
                tests++; if (x_valid !== 1'b0) begin fails++; $display("FAIL b2b_prepop_valid got %b exp 0", x_valid); end
                for (int i = 0; i < 3 * FW; i++) begin
                    @(negedge clk);
                    tests++; if (x !== exp_bit(w[i / FW], i % FW)) begin fails++; $display("FAIL b2b_bit%0d got %b exp %b", i, x, exp_bit(w[i / FW], i % FW)); end
                    tests++; if (x_valid !== 1'b1) begin fails++; $display("FAIL b2b_gap%0d x_valid got %b exp 1", i, x_valid); end
                    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy%0d got %b exp 1", i, busy); end
                end
                @(negedge clk);
                ws_exp = ws_exp + 10'd3;
                tests++; if (x_valid !== 1'b0) begin fails++; $display("FAIL b2b_end_valid got %b exp 0", x_valid); end
                tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_end_busy got %b exp 0", busy); end
                tests++; if (words_sent !== ws_exp) begin fails++; $display("FAIL b2b_words got %0d exp %0d", words_sent, ws_exp); end
            end
        join
    endtask

    task automatic test_full_fifo();
        logic [6:0] rdy_exp;
        rdy_exp = 7'b1111100;  // cycle 0 at MSB: occupancy reaches 4 after the 5th write
        fork
            begin
                int unsigned acc;
                acc = 0;
                for (int c = 0; c < 7; c++) begin
                    if (c < 6) begin in_valid = 1'b1; in_data = 8'h10 + 8'(acc); end
                    else in_valid = 1'b0;
                    tests++; if (in_ready !== rdy_exp[6 - c]) begin fails++; $display("FAIL full_in_ready cyc%0d got %b exp %b", c, in_ready, rdy_exp[6 - c]); end
                    if (c < 6 && rdy_exp[6 - c]) acc++;
                    if (c < 6) @(negedge clk);
                end
            end
            begin
                @(negedge clk);
                tests++; if (x_valid !== 1'b0) begin fails++; $display("FAIL full_prepop_valid got %b exp 0", x_valid); end
                for (int i = 0; i < 5 * FW; i++) begin
                    @(negedge clk);
                    tests++; if (x !== exp_bit(8'h10 + 8'(i / FW), i % FW)) begin fails++; $display("FAIL full_bit%0d got %b exp %b", i, x, exp_bit(8'h10 + 8'(i / FW), i % FW)); end
                    tests++; if (x_valid !== 1'b1) begin fails++; $display("FAIL full_valid%0d got %b exp 1", i, x_valid); end
                end
                @(negedge clk);
                ws_exp = ws_exp + 10'd5;
                tests++; if (x_valid !== 1'b0) begin fails++; $display("FAIL full_extra_word x_valid got %b exp 0", x_valid); end
                tests++; if (words_sent !== ws_exp) begin fails++; $display("FAIL full_words got %0d exp %0d", words_sent, ws_exp); end
                tests++; if (busy !== 1'b0) begin fails++; $display("FAIL full_busy got %b exp 0", busy); end
            end
        join
    endtask

    task automatic test_mid_reset();
        logic [3:0] hv;
        hv = 4'b1100;  // first four bits of 8'hC3
        in_data = 8'hC3; in_valid = 1'b1;
        @(negedge clk); in_data = 8'h99;
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            tests++; if (x !== hv[3 - i]) begin fails++; $display("FAIL midrst_bit%0d got %b exp %b", i, x, hv[3 - i]); end
        end
        rst = 1'b0;
        #1;
        ws_exp = '0;
        tests++; if (x !== 1'b1) begin fails++; $display("FAIL midrst_x got %b exp 1", x); end
        tests++; if (x_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got %b exp 0", x_valid); end
        tests++; if (words_sent !== 10'd0) begin fails++; $display("FAIL midrst_words got %0d exp 0", words_sent); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b exp 0", busy); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL midrst_in_ready got %b exp 0", in_ready); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        tests++; if (x_valid !== 1'b0) begin fails++; $display("FAIL midrst_discard_valid got %b exp 0", x_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_discard_busy got %b exp 0", busy); end
        in_data = 8'h3C; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < FW; i++) begin
            @(negedge clk);
            tests++; if (x !== exp_bit(8'h3C, i)) begin fails++; $display("FAIL midrst_next_bit%0d got %b exp %b", i, x, exp_bit(8'h3C, i)); end
            tests++; if (x_valid !== 1'b1) begin fails++; $display("FAIL midrst_next_valid%0d got %b exp 1", i, x_valid); end
        end
        @(negedge clk);
        ws_exp = ws_exp + 10'd1;
        tests++; if (words_sent !== ws_exp) begin fails++; $display("FAIL midrst_next_words got %0d exp %0d", words_sent, ws_exp); end
        tests++; if (x !== 1'b1) begin fails++; $display("FAIL midrst_next_idle got %b exp 1", x); end
    endtask

`ifdef FSM_SER_PARITY_EN
    task automatic test_parity();
        logic [8:0] hv;
        hv = 9'b0_0000_1111;  // 8'h07 then parity 1
        in_data = 8'h07; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            tests++; if (x !== hv[8 - i]) begin fails++; $display("FAIL parity_bit%0d got %b exp %b", i, x, hv[8 - i]); end
            tests++; if (x_valid !== 1'b1) begin fails++; $display("FAIL parity_valid%0d got %b exp 1", i, x_valid); end
            tests++; if (words_sent !== ws_exp) begin fails++; $display("FAIL parity_words_early%0d got %0d exp %0d", i, words_sent, ws_exp); end
        end
        @(negedge clk);
        ws_exp = ws_exp + 10'd1;
        tests++; if (words_sent !== ws_exp) begin fails++; $display("FAIL parity_words got %0d exp %0d", words_sent, ws_exp); end
        tests++; if (x_valid !== 1'b0) begin fails++; $display("FAIL parity_end_valid got %b exp 0", x_valid); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_full_fifo();
        test_mid_reset();
`ifdef FSM_SER_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
